multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback over the shared datapath: the single memory port, ALU, register file and PC. Drives the instruction-class flags consumed by immediate generation (is_LUI … is_JALR) and the datapath mux and enable strobes. Also keeps a retired-instruction counter and a sticky illegal-instruction halt.

Parameters:
RESET_PC_WE, 1'b0, value driven on pc_we while rst is high (kept 0; PC reset owned by PC register)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
inst  input  32  instruction register output (stable after FETCH completes)
mem_ready  input  1  memory port done; read data valid / write accepted this cycle
br_taken  input  1  branch comparator result for current B-type (funct3-resolved in datapath)
mem_req  output  1  memory port request
mem_we  output  1  memory write (store)
ir_we  output  1  load IR and old_pc register from memory data / PC
pc_we  output  1  PC write enable
pc_sel  output  1  0 = PC+4, 1 = target adder output
reg_we  output  1  register file write enable
wb_sel  output  2  00 ALU, 01 MEM, 10 PC+4 (old_pc+4), 11 IMM
alu_src_a  output  1  0 rs1, 1 old_pc
alu_src_b  output  1  0 rs2, 1 imm
is_LUI, is_AUIPC, is_I_type, is_S_type, is_Iload_type, is_B_type, is_JAL, is_JALR  output  1 each  one-hot class flags
illegal  output  1  sticky illegal-opcode flag
instret  output  INSTRET_W  retired-instruction count
state  output  3  FSM state for debug: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH; instret=0; illegal=0.
  - While rst is high, all strobes are 0: mem_req, mem_we, ir_we, pc_we, reg_we, all class flags.
  - First mem_req is in the first clock after deassertion.
  - Reset mid-instruction abandons it with no writes.
- Opcode decode (inst[6:0]):
  - 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 B, 0000011 load, 0100011 S, 0010011 I, 0110011 R (no flag).
  - Anything else is illegal.
- Class flags: combinational from inst, forced 0 in FETCH and HALT. At most one high.
- FETCH:
  - mem_req=1, mem_we=0, held until mem_ready.
  - On mem_ready: ir_we=1, pc_we=1, pc_sel=0, then go to DECODE.
  - Without mem_ready: stay in FETCH, no strobes.
- DECODE: one cycle, no strobes. Illegal → HALT, illegal<=1. Otherwise → EXECUTE.
- EXECUTE: one cycle.
  - Operand select: alu_src_a=1 for AUIPC, else 0. alu_src_b=0 for R and B, else 1.
  - B: pc_we=br_taken, pc_sel=1; retire; → FETCH.
  - Load or S → MEM.
  - All others → WB.
- MEM:
  - mem_req=1; mem_we=1 for S only; alu_src_b=1 held.
  - Wait for mem_ready.
  - On mem_ready: load → WB; S → retire, → FETCH.
- WB:
  - reg_we=1; retire; → FETCH.
  - wb_sel: ALU for R, I and AUIPC; MEM for load; PC+4 for JAL and JALR; IMM for LUI.
  - JAL and JALR also assert pc_we=1, pc_sel=1 (JALR target LSB cleared in datapath).
- Retire: instret increments by 1 on the transition into FETCH from EXECUTE, MEM or WB. Wraps from all-ones to 0.
- HALT: absorbing. No strobes, instret frozen, illegal held at 1. Only rst exits.
- Latency with mem_ready asserted on the first request cycle:
  - ALU, LUI, AUIPC, jumps: 4 cycles.
  - B: 3 cycles.
  - S: 4 cycles.
  - Load: 5 cycles.
- Each additional wait cycle on mem_ready adds one cycle.
- mem_ready outside FETCH/MEM is ignored.
- mem_req drops in the cycle after mem_ready is sampled.

Test Plan:
- Reset, then 0x00500093 (addi x1,x0,5) with mem_ready tied 1 → states 0,1,2,4,0. ir_we and pc_we (pc_sel=0) in cycle 0. is_I_type=1, alu_src_b=1 in EXECUTE. reg_we=1, wb_sel=00 in WB. instret=1.
- 0x0040A103 (lw x2,4(x1)), mem_ready low 2 cycles in MEM → MEM held 3 cycles with mem_req=1, mem_we=0. is_Iload_type=1. WB has wb_sel=01, reg_we=1. Total 7 cycles.
- 0x00000463 (beq) with br_taken=1, then again with br_taken=0 → 3 cycles each. EXECUTE pc_we=1/pc_sel=1, then pc_we=0. No reg_we. instret +2.
- 0x010000EF (jal x1,16) → is_JAL=1. WB has reg_we=1, wb_sel=10, pc_we=1, pc_sel=1.
- 0x00000000 → DECODE → HALT (state=5), illegal=1. No further mem_req for 10 cycles; instret unchanged. rst pulse → state=0, illegal=0, instret=0.
- rst asserted mid-MEM of a store → all strobes 0 immediately. No mem_we after release; fetch restarts.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I core.
// Walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB over the
// shared datapath. It drives the instruction-class flags, the mux selects and
// the write strobes, counts retired instructions, and latches a sticky halt
// when it sees an illegal opcode.
module multicycle_controller #(
    parameter logic RESET_PC_WE = 1'b0,
    parameter int   INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst,
    input  logic                 mem_ready,
    input  logic                 br_taken,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 alu_src_a,
    output logic                 alu_src_b,
    output logic                 is_LUI,
    output logic                 is_AUIPC,
    output logic                 is_I_type,
    output logic                 is_S_type,
    output logic                 is_Iload_type,
    output logic                 is_B_type,
    output logic                 is_JAL,
    output logic                 is_JALR,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t cur_state;

    logic dec_lui, dec_auipc, dec_jal, dec_jalr, dec_b;
    logic dec_load, dec_s, dec_i, dec_r, dec_legal;
    logic flags_on;
    logic pc_we_c;

    // Only the opcode field matters here; the remaining bits are reduced into
    // a deliberately unused net so the full instruction port stays visible.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[31:7];

    assign state = cur_state;

    // Opcode decode of the instruction register into one-hot class bits.
    always_comb begin
        dec_lui   = 1'b0;
        dec_auipc = 1'b0;
        dec_jal   = 1'b0;
        dec_jalr  = 1'b0;
        dec_b     = 1'b0;
        dec_load  = 1'b0;
        dec_s     = 1'b0;
        dec_i     = 1'b0;
        dec_r     = 1'b0;
        case (inst[6:0])
            7'b0110111: dec_lui   = 1'b1;
            7'b0010111: dec_auipc = 1'b1;
            7'b1101111: dec_jal   = 1'b1;
            7'b1100111: dec_jalr  = 1'b1;
            7'b1100011: dec_b     = 1'b1;
            7'b0000011: dec_load  = 1'b1;
            7'b0100011: dec_s     = 1'b1;
            7'b0010011: dec_i     = 1'b1;
            7'b0110011: dec_r     = 1'b1;
            default: ;
        endcase
        dec_legal = dec_lui | dec_auipc | dec_jal | dec_jalr | dec_b |
                    dec_load | dec_s | dec_i | dec_r;
    end

    // The IR contents are stale during FETCH and meaningless in HALT, so the
    // class flags are suppressed there and while reset is held.
    assign flags_on      = !rst && (cur_state != S_FETCH) && (cur_state != S_HALT);
    assign is_LUI        = flags_on & dec_lui;
    assign is_AUIPC      = flags_on & dec_auipc;
    assign is_I_type     = flags_on & dec_i;
    assign is_S_type     = flags_on & dec_s;
    assign is_Iload_type = flags_on & dec_load;
    assign is_B_type     = flags_on & dec_b;
    assign is_JAL        = flags_on & dec_jal;
    assign is_JALR       = flags_on & dec_jalr;

    // State sequencing, retire counting and the sticky illegal latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_FETCH;
            instret   <= '0;
            illegal   <= 1'b0;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    if (mem_ready) cur_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        cur_state <= S_HALT;
                        illegal   <= 1'b1;
                    end else begin
                        cur_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (dec_b) begin
                        cur_state <= S_FETCH;
                        instret   <= instret + INSTRET_ONE;
                    end else if (dec_load || dec_s) begin
                        cur_state <= S_MEM;
                    end else begin
                        cur_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (dec_s) begin
                            cur_state <= S_FETCH;
                            instret   <= instret + INSTRET_ONE;
                        end else begin
                            cur_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    cur_state <= S_FETCH;
                    instret   <= instret + INSTRET_ONE;
                end
                S_HALT: begin
                    cur_state <= S_HALT;
                end
                default: begin
                    cur_state <= S_FETCH;
                end
            endcase
        end
    end

    // Datapath strobes and selects for the current state; everything is
    // forced quiet while reset is held so an abandoned access never writes.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we_c   = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        if (!rst) begin
            case (cur_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we_c = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    alu_src_a = dec_auipc;
                    alu_src_b = !(dec_r || dec_b);
                    if (dec_b) begin
                        pc_we_c = br_taken;
                        pc_sel  = 1'b1;
                    end
                end
                S_MEM: begin
                    alu_src_a = dec_auipc;
                    alu_src_b = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = dec_s;
                end
                S_WB: begin
                    alu_src_a = dec_auipc;
                    alu_src_b = !(dec_r || dec_b);
                    reg_we    = 1'b1;
                    if (dec_load) begin
                        wb_sel = WB_MEM;
                    end else if (dec_jal || dec_jalr) begin
                        wb_sel  = WB_PC4;
                        pc_we_c = 1'b1;
                        pc_sel  = 1'b1;
                    end else if (dec_lui) begin
                        wb_sel = WB_IMM;
                    end else begin
                        wb_sel = WB_ALU;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_we = rst ? RESET_PC_WE : pc_we_c;

endmodule
